// File: rtl/simplerisc_pkg.sv
// Shared SimpleRisc definitions: MA-stage FSM encoding, default widths and
// the watchdog limit used when MA_TIMEOUT_EN is defined.
package simplerisc_pkg;

  localparam int unsigned MA_DATA_W        = 32;
  localparam int unsigned MA_TIMEOUT_LIMIT = 255;
  localparam int unsigned WDOG_W           = 8;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] ST_BUSY = 1'b1;

  // An instruction needs data memory when it is a load or a store.
  function automatic logic is_mem_op(input logic is_ld, input logic is_st);
    return is_ld | is_st;
  endfunction

endpackage

// File: rtl/ma_watchdog.sv
// Busy-cycle watchdog for the MA stage; instantiated only with MA_TIMEOUT_EN.
// o_expire_c fires on the tick that brings the count up to LIMIT.
module ma_watchdog
  import simplerisc_pkg::*;
#(
  parameter int unsigned LIMIT = MA_TIMEOUT_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expire_c
);

  localparam logic [WDOG_W-1:0] LAST_COUNT = WDOG_W'(LIMIT - 1);

  logic [WDOG_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= r_count + WDOG_W'(1);
    end
  end

  assign o_expire_c = i_tick && (r_count == LAST_COUNT);

endmodule

// File: rtl/memory_access_unit.sv
// SimpleRisc memory-access stage: issues ld/st over a req/ack handshake and
// presents a registered one-cycle result bundle to RW. Optional watchdog: MA_TIMEOUT_EN.
module memory_access_unit
  import simplerisc_pkg::*;
#(
  parameter int unsigned DATA_W         = MA_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = MA_TIMEOUT_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              in_is_ld,
  input  logic              in_is_st,
  input  logic              in_is_call,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_ld_result,
  output logic [DATA_W-1:0] out_pc,
  output logic              out_is_ld,
  output logic              out_is_call,
  output logic              mem_err
);

  logic [STATE_W-1:0] r_state, w_state_nxt;

  logic              r_mem_req,    w_mem_req_nxt;
  logic              r_mem_we,     w_mem_we_nxt;
  logic [DATA_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic [DATA_W-1:0] r_cap_pc,     w_cap_pc_nxt;
  logic              r_cap_is_ld,  w_cap_is_ld_nxt;
  logic              r_cap_is_call, w_cap_is_call_nxt;

  logic              r_out_valid,  w_out_valid_nxt;
  logic [DATA_W-1:0] r_out_alu,    w_out_alu_nxt;
  logic [DATA_W-1:0] r_out_ldr,    w_out_ldr_nxt;
  logic [DATA_W-1:0] r_out_pc,     w_out_pc_nxt;
  logic              r_out_is_ld,  w_out_is_ld_nxt;
  logic              r_out_is_call, w_out_is_call_nxt;
  logic              r_mem_err,    w_mem_err_nxt;

  logic w_busy;
  logic w_accept;
  logic w_expire;

  assign w_busy   = (r_state == ST_BUSY);
  assign w_accept = (r_state == ST_IDLE) && in_valid && is_mem_op(in_is_ld, in_is_st);

`ifdef MA_TIMEOUT_EN
  ma_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (!w_busy),
    .i_tick     (w_busy && !mem_ack),
    .o_expire_c (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^WDOG_W'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cap_pc      <= '0;
      r_cap_is_ld   <= 1'b0;
      r_cap_is_call <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_alu     <= '0;
      r_out_ldr     <= '0;
      r_out_pc      <= '0;
      r_out_is_ld   <= 1'b0;
      r_out_is_call <= 1'b0;
      r_mem_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_cap_pc      <= w_cap_pc_nxt;
      r_cap_is_ld   <= w_cap_is_ld_nxt;
      r_cap_is_call <= w_cap_is_call_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_alu     <= w_out_alu_nxt;
      r_out_ldr     <= w_out_ldr_nxt;
      r_out_pc      <= w_out_pc_nxt;
      r_out_is_ld   <= w_out_is_ld_nxt;
      r_out_is_call <= w_out_is_call_nxt;
      r_mem_err     <= w_mem_err_nxt;
    end
  end

  // Next-state and next-output logic; the memory address doubles as the
  // captured ALU result so it is not stored twice.
  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_we_nxt      = r_mem_we;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_cap_pc_nxt      = r_cap_pc;
    w_cap_is_ld_nxt   = r_cap_is_ld;
    w_cap_is_call_nxt = r_cap_is_call;
    w_out_valid_nxt   = 1'b0;
    w_out_alu_nxt     = r_out_alu;
    w_out_ldr_nxt     = r_out_ldr;
    w_out_pc_nxt      = r_out_pc;
    w_out_is_ld_nxt   = r_out_is_ld;
    w_out_is_call_nxt = r_out_is_call;
    w_mem_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mem_req_nxt     = 1'b1;
          w_mem_we_nxt      = in_is_st & ~in_is_ld;
          w_mem_addr_nxt    = in_alu_result;
          w_mem_wdata_nxt   = in_store_data;
          w_cap_pc_nxt      = in_pc;
          w_cap_is_ld_nxt   = in_is_ld;
          w_cap_is_call_nxt = in_is_call;
          w_state_nxt       = ST_BUSY;
        end else if (in_valid) begin
          w_out_valid_nxt   = 1'b1;
          w_out_alu_nxt     = in_alu_result;
          w_out_ldr_nxt     = '0;
          w_out_pc_nxt      = in_pc;
          w_out_is_ld_nxt   = in_is_ld;
          w_out_is_call_nxt = in_is_call;
        end
      end
      ST_BUSY: begin
        if (mem_ack || w_expire) begin
          w_mem_req_nxt     = 1'b0;
          w_out_valid_nxt   = 1'b1;
          w_out_alu_nxt     = r_mem_addr;
          w_out_ldr_nxt     = (mem_ack && r_cap_is_ld) ? mem_rdata : '0;
          w_out_pc_nxt      = r_cap_pc;
          w_out_is_ld_nxt   = r_cap_is_ld;
          w_out_is_call_nxt = r_cap_is_call;
          w_mem_err_nxt     = !mem_ack;
          w_state_nxt       = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign stall          = w_busy || w_accept;
  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign out_valid      = r_out_valid;
  assign out_alu_result = r_out_alu;
  assign out_ld_result  = r_out_ldr;
  assign out_pc         = r_out_pc;
  assign out_is_ld      = r_out_is_ld;
  assign out_is_call    = r_out_is_call;
  assign mem_err        = r_mem_err;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: transaction-level reference
// model checked every cycle, directed scenarios, then random traffic.
module tb_memory_access_unit;

  localparam int unsigned DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_alu_result, in_store_data, in_pc;
  logic          in_is_ld, in_is_st, in_is_call;
  logic          stall, mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          mem_ack;
  logic          out_valid;
  logic [DW-1:0] out_alu_result, out_ld_result, out_pc;
  logic          out_is_ld, out_is_call, mem_err;

  always #5 clk = ~clk;

  memory_access_unit #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_pc          (in_pc),
    .in_is_ld       (in_is_ld),
    .in_is_st       (in_is_st),
    .in_is_call     (in_is_call),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .out_valid      (out_valid),
    .out_alu_result (out_alu_result),
    .out_ld_result  (out_ld_result),
    .out_pc         (out_pc),
    .out_is_ld      (out_is_ld),
    .out_is_call    (out_is_call),
    .mem_err        (mem_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one pending memory transaction plus the expected outputs.
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  bit [DW-1:0] m_pc   = '0;
  bit          m_ld   = 1'b0;
  bit          m_call = 1'b0;
  bit          e_req = 0, e_we = 0, e_valid = 0, e_isld = 0, e_call = 0, e_err = 0;
  bit [DW-1:0] e_addr = '0, e_wdata = '0, e_alu = '0, e_ldr = '0, e_pc = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input bit [DW-1:0] alu, input bit [DW-1:0] sd,
                            input bit [DW-1:0] pc, input bit ld, input bit st, input bit call,
                            input bit ack, input bit [DW-1:0] rd);
    bit          done;
    bit [DW-1:0] lres;
    if (rst) begin
      m_busy = 0; m_age = 0;
      e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_valid = 0;
      e_alu = '0; e_ldr = '0; e_pc = '0; e_isld = 0; e_call = 0; e_err = 0;
    end else begin
      e_valid = 0;
      e_err   = 0;
      if (!m_busy) begin
        if (v && (ld || st)) begin
          m_busy = 1; m_age = 0;
          e_req = 1; e_we = st && !ld; e_addr = alu; e_wdata = sd;
          m_pc = pc; m_ld = ld; m_call = call;
        end else if (v) begin
          e_valid = 1; e_alu = alu; e_ldr = '0; e_pc = pc; e_isld = ld; e_call = call;
        end
      end else begin
        done = 0;
        lres = '0;
        if (ack) begin
          done = 1;
          if (m_ld) lres = rd;
        end else begin
          m_age++;
`ifdef MA_TIMEOUT_EN
          if (m_age == TO) begin
            done  = 1;
            e_err = 1;
          end
`endif
        end
        if (done) begin
          m_busy = 0;
          e_req = 0; e_valid = 1; e_alu = e_addr; e_ldr = lres;
          e_pc = m_pc; e_isld = m_ld; e_call = m_call;
        end
      end
    end
  endtask

  // One clock: drive inputs, check stall, advance model, compare registered outputs.
  task automatic step(input bit rst, input bit v, input bit [DW-1:0] alu, input bit [DW-1:0] sd,
                      input bit [DW-1:0] pc, input bit ld, input bit st, input bit call,
                      input bit ack, input bit [DW-1:0] rd);
    reset = rst; in_valid = v; in_alu_result = alu; in_store_data = sd; in_pc = pc;
    in_is_ld = ld; in_is_st = st; in_is_call = call; mem_ack = ack; mem_rdata = rd;
    #1;
    if (!rst) chk("stall", DW'(stall), DW'(m_busy || (v && (ld || st))));
    model_edge(rst, v, alu, sd, pc, ld, st, call, ack, rd);
    @(posedge clk);
    #1;
    chk("mem_req",        DW'(mem_req),     DW'(e_req));
    chk("mem_we",         DW'(mem_we),      DW'(e_we));
    chk("mem_addr",       mem_addr,         e_addr);
    chk("mem_wdata",      mem_wdata,        e_wdata);
    chk("out_valid",      DW'(out_valid),   DW'(e_valid));
    chk("out_alu_result", out_alu_result,   e_alu);
    chk("out_ld_result",  out_ld_result,    e_ldr);
    chk("out_pc",         out_pc,           e_pc);
    chk("out_is_ld",      DW'(out_is_ld),   DW'(e_isld));
    chk("out_is_call",    DW'(out_is_call), DW'(e_call));
    chk("mem_err",        DW'(mem_err),     DW'(e_err));
    @(negedge clk);
  endtask

  task automatic idle(input bit ack, input bit [DW-1:0] rd);
    step(0, 0, '0, '0, '0, 0, 0, 0, ack, rd);
  endtask

  initial begin
    // Reset with a load presented: nothing may be issued.
    step(1, 1, 32'h40, 0, 32'h4, 1, 0, 0, 0, 0);
    step(1, 1, 32'h40, 0, 32'h4, 1, 0, 0, 0, 0);
    chk("lit_reset_req",   DW'(mem_req),   32'h0);
    chk("lit_reset_valid", DW'(out_valid), 32'h0);
    chk("lit_reset_alu",   out_alu_result, 32'h0);

    // ALU pass-through.
    step(0, 1, 32'h10, 0, 32'h100, 0, 0, 0, 0, 0);
    chk("lit_pt_valid", DW'(out_valid), 32'h1);
    chk("lit_pt_alu",   out_alu_result, 32'h10);
    chk("lit_pt_ldr",   out_ld_result,  32'h0);
    chk("lit_pt_pc",    out_pc,         32'h100);

    // Load, ack on the third BUSY cycle.
    step(0, 1, 32'h40, 32'h55, 32'h104, 1, 0, 0, 0, 0);
    chk("lit_ld_req",  DW'(mem_req), 32'h1);
    chk("lit_ld_addr", mem_addr,     32'h40);
    chk("lit_ld_we",   DW'(mem_we),  32'h0);
    idle(0, 0);
    idle(0, 0);
    chk("lit_ld_stall", DW'(stall), 32'h1);
    idle(1, 32'hCAFE_F00D);
    chk("lit_ld_valid", DW'(out_valid),  32'h1);
    chk("lit_ld_ldr",   out_ld_result,   32'hCAFE_F00D);
    chk("lit_ld_isld",  DW'(out_is_ld),  32'h1);
    chk("lit_ld_req0",  DW'(mem_req),    32'h0);
    idle(0, 0);
    chk("lit_ld_pulse", DW'(out_valid),  32'h0);

    // Store with immediate ack; read data must not leak into the result.
    step(0, 1, 32'h80, 32'h1234, 32'h108, 0, 1, 0, 0, 0);
    chk("lit_st_we",    DW'(mem_we), 32'h1);
    chk("lit_st_wdata", mem_wdata,   32'h1234);
    idle(1, 32'hDEAD_BEEF);
    chk("lit_st_valid", DW'(out_valid), 32'h1);
    chk("lit_st_ldr",   out_ld_result,  32'h0);

    // Call pass-through with spurious ack, then back-to-back load; both flags -> load.
    step(0, 1, 32'h7, 0, 32'h200, 0, 0, 1, 1, 32'h1111);
    chk("lit_call_flag", DW'(out_is_call), 32'h1);
    chk("lit_call_pc",   out_pc,           32'h200);
    step(0, 1, 32'h44, 32'h9, 32'h204, 1, 1, 0, 0, 0);
    chk("lit_b2b_req", DW'(mem_req), 32'h1);
    chk("lit_b2b_we",  DW'(mem_we),  32'h0);
    step(0, 1, 32'h99, 0, 32'h300, 0, 0, 0, 1, 32'h2222);
    chk("lit_b2b_ldr", out_ld_result, 32'h2222);

    // No ack: watchdog expiry, or indefinite wait when the watchdog is absent.
    step(0, 1, 32'hC0, 0, 32'h400, 1, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) idle(0, 0);
    chk("lit_to_req_held", DW'(mem_req), 32'h1);
    idle(0, 0);
`ifdef MA_TIMEOUT_EN
    chk("lit_to_err",   DW'(mem_err),   32'h1);
    chk("lit_to_valid", DW'(out_valid), 32'h1);
    chk("lit_to_req",   DW'(mem_req),   32'h0);
    chk("lit_to_ldr",   out_ld_result,  32'h0);
    idle(0, 0);
    chk("lit_to_err_pulse", DW'(mem_err), 32'h0);
`else
    idle(0, 0);
    chk("lit_wait_req", DW'(mem_req), 32'h1);
    chk("lit_wait_err", DW'(mem_err), 32'h0);
    idle(1, 32'h3333);
    chk("lit_wait_ldr", out_ld_result, 32'h3333);
`endif

    // Reset mid-transaction abandons it.
    step(0, 1, 32'hE0, 0, 32'h500, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4444);
    chk("lit_rst_mid_req",   DW'(mem_req),   32'h0);
    chk("lit_rst_mid_valid", DW'(out_valid), 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bit [1:0] kind;
      kind = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) != 0),
           $urandom, $urandom, $urandom,
           kind[0], kind[1], 1'($urandom),
           ($urandom_range(0, 4) < 2), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
